instr_encoder: RTL and testbench
================================

# instr_encoder

Pipelined RV32I instruction encoder for the bring-up and self-test path of the villano core. It accepts decoded instruction fields, packs them into 32-bit machine words in the six base formats, and streams them with addresses to the instruction-memory loader over a valid/ready handshake. It is the inverse of the decode-side control logic, and it uses the same `imm_src` format encodings wherever they overlap.

## Interface
Parameters:
- `ADDR_W`, default 32: width of the generated word address.
- `BASE_ADDR`, default 0: first address emitted after reset, flush or last.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `flush` input 1: synchronous clear of the pipeline and the address counter.
- `in_valid` input 1: the field bundle is valid.
- `in_ready` output 1: the encoder accepts the bundle this cycle.
- `in_fmt` input 3: instruction format; 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are reserved.
- `in_op` input 7: opcode.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices.
- `in_funct3` input 3: funct3 field.
- `in_funct7b5` input 1: funct7 bit 5; R format only.
- `in_imm` input 32: signed immediate; byte offset for B and J; full value for U.
- `in_last` input 1: marks the final word of a program.
- `out_valid` output 1: the encoded word is valid.
- `out_ready` input 1: the loader accepts the word.
- `out_word` output 32: encoded instruction.
- `out_addr` output `ADDR_W`: address of `out_word`.
- `out_err` output 1: the word was flagged as malformed.
- `done` output 1: one-cycle pulse when the last word is accepted.
- `err_cnt` output 8: saturating count of accepted words with `out_err` set.

## Operation
- Bit packing follows RV32I exactly; only the bits each format defines are taken from the inputs, and all other bits are zero.
  - R: `{1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, op}`.
  - I: `imm[11:0]` in bits 31:20.
  - S: `imm[11:5]` in bits 31:25 and `imm[4:0]` in bits 11:7.
  - B: `imm[12|10:5]` in bits 31:25 and `imm[4:1|11]` in bits 11:7.
  - U: `imm[31:12]` in bits 31:12.
  - J: `imm[20|10:1|11|19:12]` in bits 31:12.
- Reserved format (6 or 7): `out_word` = 0x00000013 (NOP) and `out_err` = 1.
- Address counter:
  - Starts at `BASE_ADDR`.
  - Advances by 4 on each output handshake (`out_valid && out_ready`).
  - Wraps modulo 2^`ADDR_W`.
  - On a handshake of a word carrying last, `done` pulses and the counter returns to `BASE_ADDR`.
- `err_cnt` increments on each handshake with `out_err` = 1 and saturates at 255. It is cleared only by reset, not by flush.
- `flush` drops any held word: `out_valid` becomes 0 and the address returns to `BASE_ADDR`. An input presented in the same cycle as `flush` is discarded.

## Timing
- Reset values: `out_valid` 0, `out_word` 0, `out_addr` `BASE_ADDR`, `out_err` 0, `done` 0, `err_cnt` 0, and `in_ready` 1 in the first cycle after reset is released.
- Output register stage, with a latency of 1 cycle from the input handshake to `out_valid`.
- `in_ready` = `!out_valid || out_ready`, giving a full-throughput stream with no bubbles.
- While `out_valid && !out_ready`:
  - `out_word`, `out_addr` and `out_err` are held stable.
  - `in_ready` is 0.
- A simultaneous output handshake and input handshake loads the new word in the same cycle; `out_addr` becomes the previous address + 4.
- `done` is asserted the cycle after the handshake of the last word.
- Priority, highest first: `reset_n` low, then `flush`, then normal operation.

## Configuration
- `INSTR_ENCODER_IMM_CHECK_EN`, when defined, adds immediate range checking. `out_err` is set, while the word is still encoded by truncation, when:
  - I or S format: `imm` is outside [-2048, 2047].
  - B format: `imm` is outside [-4096, 4094] or is odd.
  - J format: `imm` is outside [-2^20, 2^20-2] or is odd.
  - U format: `imm[11:0]` is nonzero.
- When undefined: immediates are silently truncated, and `out_err` is raised only for reserved formats.

## Structure
- Shared package `riscv_pkg`:
  - `fmt_e` enum for the format codes.
  - Opcode constants (0x33, 0x13, 0x03, 0x23, 0x63, 0x37, 0x6F).
  - `NOP_WORD` = 0x00000013.
- One combinational sub-module `imm_packer`:
  - Inputs: `fmt` and `imm`.
  - Outputs: the immediate bit fields placed in a 32-bit mask, and the range-error flag.
- The top level holds the handshake, the output register, the address counter and the error counter.

## Test plan
- Reset, then I format, op 0x13, rd 1, rs1 0, funct3 0, imm 5 -> one cycle later `out_word` 0x00500093, `out_addr` 0x0, `out_err` 0.
- Back-to-back S format (op 0x23, rs1 1, rs2 2, funct3 2, imm 8) followed by R format (op 0x33, rd 3, rs1 1, rs2 2, funct7b5 1) with `out_ready` held at 1 -> 0x0020A423 at address 0x0, then 0x402081B3 at address 0x4, with no bubble.
- J format, op 0x6F, rd 1, imm 8, `in_last` 1, with `out_ready` low for 3 cycles:
  - `out_word` 0x008000EF is held stable and `in_ready` is 0 throughout.
  - `done` pulses after `out_ready` rises.
  - The next word is emitted at `BASE_ADDR`.
- B format with imm 3, built with the macro -> `out_err` 1 and `err_cnt` 1. The same stimulus built without the macro -> `out_err` 0.
- `in_fmt` 7 -> `out_word` 0x00000013 and `out_err` 1. Then `flush` while the word is held -> `out_valid` 0, the next word is emitted at `BASE_ADDR`, and `err_cnt` is unchanged.
- `ADDR_W` = 4, 5 words streamed -> addresses 0x0, 0x4, 0x8, 0xC, 0x0, showing the wrap.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32I format codes, opcode constants and the NOP word.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_RSV6 = 3'd6,
      FMT_RSV7 = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/imm_packer.sv
`default_nettype none
// ============================================================================
// Module   : imm_packer
// Brief    : Places immediate bits for each format; optional range check
//            enabled by INSTR_ENCODER_IMM_CHECK_EN.
// Revision : 1.0
// ============================================================================
module imm_packer
   import riscv_pkg::*;
(
   input  logic [2:0]  i_fmt,
   input  logic [31:0] i_imm,
   output logic [31:0] o_imm_bits,
   output logic        o_range_err
);

   fmt_e w_fmt;
   assign w_fmt = fmt_e'(i_fmt);

   always_comb begin
      o_imm_bits = '0;
      case (w_fmt)
         FMT_I:   o_imm_bits = {i_imm[11:0], 20'b0};
         FMT_S:   o_imm_bits = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
         FMT_B:   o_imm_bits = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
         FMT_U:   o_imm_bits = {i_imm[31:12], 12'b0};
         FMT_J:   o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
         default: o_imm_bits = '0;
      endcase
   end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
   // A value fits an N-bit signed field when all bits above N-1 copy the sign.
   logic w_fits12;
   logic w_fits13;
   logic w_fits21;
   assign w_fits12 = (i_imm[31:11] == {21{i_imm[11]}});
   assign w_fits13 = (i_imm[31:12] == {20{i_imm[12]}});
   assign w_fits21 = (i_imm[31:20] == {12{i_imm[20]}});

   always_comb begin
      o_range_err = 1'b0;
      case (w_fmt)
         FMT_I, FMT_S: o_range_err = !w_fits12;
         FMT_B:        o_range_err = !w_fits13 || i_imm[0];
         FMT_U:        o_range_err = |i_imm[11:0];
         FMT_J:        o_range_err = !w_fits21 || i_imm[0];
         default:      o_range_err = 1'b0;
      endcase
   end
`else
   assign o_range_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs RV32I fields into words and streams them with addresses.
//            Build macro INSTR_ENCODER_IMM_CHECK_EN adds immediate checking.
// Revision : 1.0
// ============================================================================
module instr_encoder
   import riscv_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7b5,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_word,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic              done,
   output logic [7:0]        err_cnt
);

   logic              r_valid;
   logic              r_err;
   logic              r_last;
   logic              r_done;
   logic [31:0]       r_word;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_err_cnt;

   logic [31:0] w_imm_bits;
   logic [31:0] w_word;
   logic        w_range_err;
   logic        w_err;
   logic        w_in_fire;
   logic        w_out_fire;
   fmt_e        w_fmt;

   imm_packer u_imm_packer (
      .i_fmt       (in_fmt),
      .i_imm       (in_imm),
      .o_imm_bits  (w_imm_bits),
      .o_range_err (w_range_err)
   );

   assign w_fmt = fmt_e'(in_fmt);

   always_comb begin
      w_word = '0;
      w_err  = w_range_err;
      case (w_fmt)
         FMT_R:        w_word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, in_op};
         FMT_I:        w_word = w_imm_bits | {12'b0, in_rs1, in_funct3, in_rd, in_op};
         FMT_S, FMT_B: w_word = w_imm_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_op};
         FMT_U, FMT_J: w_word = w_imm_bits | {20'b0, in_rd, in_op};
         default: begin
            w_word = NOP_WORD;
            w_err  = 1'b1;
         end
      endcase
   end

   assign in_ready   = !r_valid || out_ready;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_valid   <= 1'b0;
         r_word    <= '0;
         r_err     <= 1'b0;
         r_last    <= 1'b0;
         r_done    <= 1'b0;
         r_addr    <= BASE_ADDR;
         r_err_cnt <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_addr  <= BASE_ADDR;
      end else begin
         r_done <= w_out_fire && r_last;
         if (w_out_fire) begin
            r_addr <= r_last ? BASE_ADDR : r_addr + ADDR_W'(4);
            if (r_err && (r_err_cnt != 8'hFF)) begin
               r_err_cnt <= r_err_cnt + 8'd1;
            end
         end
         // A new word may replace the one leaving in the same cycle.
         if (w_in_fire) begin
            r_valid <= 1'b1;
            r_word  <= w_word;
            r_err   <= w_err;
            r_last  <= in_last;
         end else if (w_out_fire) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_word  = r_word;
   assign out_addr  = r_addr;
   assign out_err   = r_err;
   assign done      = r_done;
   assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Scoreboard bench for instr_encoder (default and 4-bit address).
// Revision : 1.0
// ============================================================================
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  in_fmt = '0;
   logic [6:0]  in_op = '0;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic        in_funct7b5 = 1'b0;
   logic [31:0] in_imm = '0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_err, done;
   logic [31:0] out_word, out_addr;
   logic [7:0]  err_cnt;
   logic        in_ready4, out_valid4, out_err4, done4;
   logic [31:0] out_word4;
   logic [3:0]  out_addr4;
   logic [7:0]  err_cnt4;

   always #5 clk = ~clk;

   instr_encoder u_dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
      .in_funct7b5(in_funct7b5), .in_imm(in_imm), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .out_addr(out_addr), .out_err(out_err), .done(done), .err_cnt(err_cnt)
   );

   instr_encoder #(.ADDR_W(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4), .in_fmt(in_fmt), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
      .in_funct7b5(in_funct7b5), .in_imm(in_imm), .in_last(in_last),
      .out_valid(out_valid4), .out_ready(out_ready), .out_word(out_word4),
      .out_addr(out_addr4), .out_err(out_err4), .done(done4), .err_cnt(err_cnt4)
   );

   typedef struct {
      logic [31:0] word;
      logic        err;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          hs_last = 0;
   int          hs_prev = 0;
   logic [31:0] m_addr = '0;
   logic [7:0]  m_errcnt = '0;
   logic        pend = 1'b0;
   logic        pend_done = 1'b0;
   logic        stop = 1'b0;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
   localparam logic IMM_CHK = 1'b1;
`else
   localparam logic IMM_CHK = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic f7, input logic [31:0] imm);
      logic [31:0] w;
      logic [31:0] regs;
      w    = 32'(op);
      regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
      case (f)
         3'd0: w = w | (32'(f7) << 30) | regs | (32'(rd) << 7);
         3'd1: w = w | (imm << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
         3'd2: w = w | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7) | regs;
         3'd3: w = w | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                     | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | regs;
         3'd4: w = w | (imm & 32'hFFFF_F000) | (32'(rd) << 7);
         3'd5: w = w | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000) | (32'(rd) << 7);
         default: w = 32'h0000_0013;
      endcase
      return w;
   endfunction

   function automatic logic model_err(input logic [2:0] f, input logic [31:0] imm);
      int s;
      s = $signed(imm);
      if (f > 3'd5) return 1'b1;
      if (!IMM_CHK) return 1'b0;
      case (f)
         3'd1, 3'd2: return (s < -2048) || (s > 2047);
         3'd3:       return (s < -4096) || (s > 4094) || imm[0];
         3'd4:       return imm[11:0] != 12'd0;
         3'd5:       return (s < -(1 << 20)) || (s > (1 << 20) - 2) || imm[0];
         default:    return 1'b0;
      endcase
   endfunction

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic f7, input logic [31:0] imm, input logic last);
      logic ok;
      exp_t x;
      in_valid = 1'b1; in_fmt = f; in_op = op; in_rd = rd; in_rs1 = rs1;
      in_rs2 = rs2; in_funct3 = f3; in_funct7b5 = f7; in_imm = imm; in_last = last;
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (ok) begin
         x.word = model_word(f, op, rd, rs1, rs2, f3, f7, imm);
         x.err  = model_err(f, imm);
         x.last = last;
         sb.push_back(x);
      end else begin
         check("send_timeout", 32'd0, 32'd1);
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every output handshake pops one expected word.
   always @(negedge clk) begin
      if (reset_n) begin
         if (pend) begin
            check("done", 32'(done), 32'(pend_done));
            check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
            check("err_cnt4", 32'(err_cnt4), 32'(m_errcnt));
            pend = 1'b0;
         end
         if (flush) begin
            if (out_valid && sb.size() > 0) void'(sb.pop_front());
            m_addr = '0;
         end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("word", out_word, e.word);
               check("addr", out_addr, m_addr);
               check("err", 32'(out_err), 32'(e.err));
               check("word4", out_word4, e.word);
               check("addr4", 32'(out_addr4), 32'(m_addr[3:0]));
               m_addr    = e.last ? 32'd0 : m_addr + 32'd4;
               pend_done = e.last;
               if (e.err && m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
               pend    = 1'b1;
               hs_prev = hs_last;
               hs_last = cyc;
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_word", out_word, 32'd0);
      check("rst_addr", out_addr, 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_errcnt", 32'(err_cnt), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // addi x1, x0, 5
      out_ready = 1'b1;
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
      @(negedge clk);
      check("t1_word", out_word, 32'h0050_0093);
      check("t1_addr", out_addr, 32'd0);
      check("t1_err", 32'(out_err), 32'd0);
      pulse_flush();

      // sw then R-type back to back
      send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 1'b0);
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0);
      @(negedge clk);
      check("t2_word", out_word, 32'h4020_81B3);
      check("t2_addr", out_addr, 32'd4);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t2_no_bubble", 32'(hs_last - hs_prev), 32'd1);

      // jal with backpressure and last
      out_ready = 1'b0;
      send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t3_hold_word", out_word, 32'h0080_00EF);
         check("t3_hold_valid", 32'(out_valid), 32'd1);
         check("t3_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t3_done", 32'(done), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t3_done_pulse", 32'(done), 32'd0);
      @(posedge clk); #1;
      send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, 1'b0);
      @(negedge clk);
      check("t3_restart_addr", out_addr, 32'd0);
      @(posedge clk); #1;

      // branch with odd offset
      send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, 1'b0);
      @(negedge clk);
      check("t4_err", 32'(out_err), 32'(IMM_CHK));
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_errcnt", 32'(err_cnt), 32'(IMM_CHK));
      @(posedge clk); #1;

      // reserved format, then flush while held
      out_ready = 1'b0;
      send(3'd7, 7'h33, 5'd4, 5'd5, 5'd6, 3'd1, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      check("t5_nop", out_word, 32'h0000_0013);
      check("t5_err", 32'(out_err), 32'd1);
      pulse_flush();
      @(negedge clk);
      check("t5_flushed", 32'(out_valid), 32'd0);
      check("t5_errcnt_kept", 32'(err_cnt), 32'(IMM_CHK));
      @(posedge clk); #1 out_ready = 1'b1;
      send(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 1'b0);
      @(negedge clk);
      check("t5_addr_base", out_addr, 32'd0);
      pulse_flush();

      // five words: the 4-bit address instance wraps
      for (int k = 0; k < 5; k++) begin
         send(3'd1, 7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 1'b0, 32'(k * 3), 1'b0);
      end
      @(negedge clk);
      check("t6_addr4_wrap", 32'(out_addr4), 32'd0);
      check("t6_addr_full", out_addr, 32'h10);
      @(posedge clk); #1;

      // random stream with random backpressure
      fork
         begin
            while (!stop) begin
               @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
            end
         end
         begin
            for (int k = 0; k < 40; k++) begin
               logic [31:0] imm;
               case ($urandom_range(0, 3))
                  0:       imm = 32'($signed($urandom_range(0, 8400)) - 4200);
                  1:       imm = $urandom();
                  2:       imm = $urandom() & 32'hFFFF_F000;
                  default: imm = 32'($signed($urandom_range(0, 4000)) - 2000) & 32'hFFFF_FFFE;
               endcase
               send(3'($urandom_range(0, 7)), 7'($urandom()), 5'($urandom()), 5'($urandom()),
                    5'($urandom()), 3'($urandom()), 1'($urandom()), imm,
                    1'($urandom_range(0, 7) == 0));
            end
            stop = 1'b1;
         end
      join
      @(posedge clk); #1 out_ready = 1'b1;
      for (int n = 0; n < 50 && sb.size() > 0; n++) @(posedge clk);
      repeat (3) @(posedge clk);
      check("drain_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
